// File: rtl/board_pixel_pipe.sv
// -----------------------------------------------------------------------------
// board_pixel_pipe
//
// Renders the 10x20 playfield into a registered RGB stream. It takes the
// vga_controller scan position, fetches the cell code from the synchronous
// board RAM, and then shades the code. Shading covers the level palette, the
// bevel edges and the line-clear flash. The VGA interface overlays these
// colours on its static frame art wherever board_hit is set.
//
// Pipeline (advances only on PIX_EN, holds otherwise):
//   S1  : board hit test, RAM address, local x/y, sync capture
//   S2  : cell_q sampled, palette/flash/bevel colour computed
//   OUT : RGB forced to 0 outside the board, delayed hs/vs
//   Colour, board_hit and sync all appear 2 strobes after their inputs.
//
// Ports:
//   CLK        in   system clock (50 MHz)
//   RESET      in   synchronous, active-high reset
//   PIX_EN     in   one-CLK pixel strobe, >= 2 CLKs apart
//   DrawX/Y    in   10-bit scan position
//   blank_in   in   1 = visible area
//   hs_in/vs_in in  active-low syncs
//   palette    in   3 level colours {R,G,B}, 4 bits per channel
//   cell_addr  out  board RAM address (row*COLS+col)
//   cell_q     in   board RAM data, valid 1 CLK after cell_addr
//   red/green/blue out  4-bit colour channels
//   hs_out/vs_out  out  syncs delayed to match colour
//   board_hit  out  pixel is inside the visible board interior
//
// Build option: define BOARD_GRID_EN to draw 0x222 grid lines on the top and
// left edges of empty cells. Without it, empty cells are entirely black.
// -----------------------------------------------------------------------------
module board_pixel_pipe #(
  parameter int BOARD_X0   = 240,
  parameter int BOARD_Y0   = 80,
  parameter int CELL_SHIFT = 4,
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int BEVEL      = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PIX_EN,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [2:0][11:0] palette,
  output logic [7:0]       cell_addr,
  input  logic [3:0]       cell_q,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             hs_out,
  output logic             vs_out,
  output logic             board_hit
);

  localparam int BOARD_W = COLS << CELL_SHIFT;
  localparam int BOARD_H = ROWS << CELL_SHIFT;
  localparam logic [CELL_SHIFT-1:0] LOC_MAX = '1;
  localparam logic [4:0] BEV5 = 5'(BEVEL);
  localparam logic [3:0] BEV4 = 4'(BEVEL);

  // ---------------------------------------------------------------- S1 logic
  // Offsets are taken at 11 bits. A pixel left of or above the board then
  // goes negative (bit 10 set) instead of wrapping into range.
  logic [10:0] dx, dy;
  logic        in_x, in_y, in_board;
  logic [7:0]  cell_addr_next;

  assign dx       = {1'b0, DrawX} - 11'(BOARD_X0);
  assign dy       = {1'b0, DrawY} - 11'(BOARD_Y0);
  assign in_x     = !dx[10] && (dx < 11'(BOARD_W));
  assign in_y     = !dy[10] && (dy < 11'(BOARD_H));
  assign in_board = blank_in && in_x && in_y;
  assign cell_addr_next = 8'((dy >> CELL_SHIFT) * COLS + (dx >> CELL_SHIFT));

  logic                  s1_hit_reg;
  logic [CELL_SHIFT-1:0] s1_lx_reg, s1_ly_reg;
  logic                  s1_hs_reg, s1_vs_reg;

  // ---------------------------------------------------------------- S2 logic
  logic [4:0]  frame_cnt_reg;
  logic        vs_prev_reg;

  // Palette slot for a cell code. Codes 1..7 map to (code-1) mod 3.
  // Codes 8..15 map to (code-8) mod 3.
  function automatic logic [1:0] pal_idx(input logic [3:0] code);
    logic [1:0] idx;
    case (code)
      4'd1, 4'd4, 4'd7, 4'd8, 4'd11, 4'd14: idx = 2'd0;
      4'd2, 4'd5, 4'd9, 4'd12, 4'd15:       idx = 2'd1;
      4'd3, 4'd6, 4'd10, 4'd13:             idx = 2'd2;
      default:                              idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [11:0] base_col;
  logic [11:0] shaded_col;
  logic [11:0] colour_next;
  logic        edge_lo, edge_hi;

  assign edge_lo = (s1_lx_reg == '0) || (s1_ly_reg == '0);
  assign edge_hi = (s1_lx_reg == LOC_MAX) || (s1_ly_reg == LOC_MAX);

  always_comb begin
    base_col = palette[pal_idx(cell_q)];
    if (cell_q[3] && frame_cnt_reg[3]) begin
      base_col = 12'hFFF;
    end
  end

  // Per-channel bevel. Lighten takes priority, so corners where both edges
  // meet come out light.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bevel
      logic [3:0] chan;
      logic [4:0] lit_sum;
      logic [3:0] lit_sat, dark_sat;
      assign chan     = base_col[gi*4 +: 4];
      assign lit_sum  = {1'b0, chan} + BEV5;
      assign lit_sat  = lit_sum[4] ? 4'hF : lit_sum[3:0];
      assign dark_sat = (chan >= BEV4) ? (chan - BEV4) : 4'h0;
      assign shaded_col[gi*4 +: 4] = edge_lo ? lit_sat :
                                     edge_hi ? dark_sat : chan;
    end
  endgenerate

  always_comb begin
    colour_next = shaded_col;
    if (cell_q == 4'd0) begin
`ifdef BOARD_GRID_EN
      colour_next = edge_lo ? 12'h222 : 12'h000;
`else
      colour_next = 12'h000;
`endif
    end
  end

  logic        s2_hit_reg;
  logic [11:0] s2_rgb_reg;
  logic        s2_hs_reg, s2_vs_reg;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cell_addr     <= 8'd0;
      s1_hit_reg    <= 1'b0;
      s1_lx_reg     <= '0;
      s1_ly_reg     <= '0;
      s1_hs_reg     <= 1'b1;
      s1_vs_reg     <= 1'b1;
      s2_hit_reg    <= 1'b0;
      s2_rgb_reg    <= 12'h000;
      s2_hs_reg     <= 1'b1;
      s2_vs_reg     <= 1'b1;
      red           <= 4'h0;
      green         <= 4'h0;
      blue          <= 4'h0;
      board_hit     <= 1'b0;
      hs_out        <= 1'b1;
      vs_out        <= 1'b1;
      frame_cnt_reg <= 5'd0;
      vs_prev_reg   <= 1'b1;
    end else if (PIX_EN) begin
      // S1. An off-board pixel leaves the RAM address where it was.
      if (in_board) begin
        cell_addr <= cell_addr_next;
      end
      s1_hit_reg <= in_board;
      s1_lx_reg  <= dx[CELL_SHIFT-1:0];
      s1_ly_reg  <= dy[CELL_SHIFT-1:0];
      s1_hs_reg  <= hs_in;
      s1_vs_reg  <= vs_in;

      // S2. Strobe spacing guarantees cell_q already reflects cell_addr.
      s2_hit_reg <= s1_hit_reg;
      s2_rgb_reg <= colour_next;
      s2_hs_reg  <= s1_hs_reg;
      s2_vs_reg  <= s1_vs_reg;

      // Output stage.
      red       <= s2_hit_reg ? s2_rgb_reg[11:8] : 4'h0;
      green     <= s2_hit_reg ? s2_rgb_reg[7:4]  : 4'h0;
      blue      <= s2_hit_reg ? s2_rgb_reg[3:0]  : 4'h0;
      board_hit <= s2_hit_reg;
      hs_out    <= s2_hs_reg;
      vs_out    <= s2_vs_reg;

      // Frame counter ticks on the vsync falling edge. It drives the flash.
      vs_prev_reg <= vs_in;
      if (vs_prev_reg && !vs_in) begin
        frame_cnt_reg <= frame_cnt_reg + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_board_pixel_pipe.sv
module tb_board_pixel_pipe;

  logic             CLK;
  logic             RESET;
  logic             PIX_EN;
  logic [9:0]       DrawX, DrawY;
  logic             blank_in, hs_in, vs_in;
  logic [2:0][11:0] palette;
  logic [7:0]       cell_addr;
  logic [3:0]       cell_q;
  logic [3:0]       red, green, blue;
  logic             hs_out, vs_out, board_hit;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BOARD_GRID_EN
  localparam logic [11:0] GRID_EXP = 12'h222;
`else
  localparam logic [11:0] GRID_EXP = 12'h000;
`endif

  board_pixel_pipe dut (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN),
    .DrawX(DrawX), .DrawY(DrawY),
    .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
    .palette(palette), .cell_addr(cell_addr), .cell_q(cell_q),
    .red(red), .green(green), .blue(blue),
    .hs_out(hs_out), .vs_out(vs_out), .board_hit(board_hit)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Board cell RAM model with a one-clock synchronous read.
  logic [3:0] mem [0:255];
  always @(posedge CLK) cell_q <= mem[cell_addr];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one pixel with a single-CLK strobe, leave a gap, and return at a negedge.
  task automatic pix(input int x, input int y, input logic bl, input logic hs, input logic vs);
    @(negedge CLK);
    DrawX = 10'(x); DrawY = 10'(y);
    blank_in = bl; hs_in = hs; vs_in = vs;
    PIX_EN = 1'b1;
    @(negedge CLK);
    PIX_EN = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'd0;
    RESET = 1'b1; PIX_EN = 1'b0;
    DrawX = '0; DrawY = '0; blank_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    palette[0] = 12'h5A3; palette[1] = 12'h0F1; palette[2] = 12'h777;
    cell_q = 4'd0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("reset_rgb",  {red, green, blue}, 12'h000);
    chk("reset_hit",  {11'd0, board_hit}, 12'd0);
    chk("reset_hs",   {11'd0, hs_out}, 12'd1);
    chk("reset_vs",   {11'd0, vs_out}, 12'd1);
    chk("reset_addr", {4'd0, cell_addr}, 12'd0);
    RESET = 1'b0;

    // Top-left corner lighten, and a 2-strobe latency check
    mem[0] = 4'd1;
    pix(240, 80, 1, 1, 1);
    chk("tl_addr", {4'd0, cell_addr}, 12'd0);
    pix(400, 100, 1, 1, 1);
    chk("tl_not_yet", {11'd0, board_hit}, 12'd0);
    pix(400, 100, 1, 1, 1);
    chk("tl_hit", {11'd0, board_hit}, 12'd1);
    chk("tl_rgb", {red, green, blue}, 12'h8D6);
    pix(400, 100, 1, 1, 1);
    chk("out400_hit", {11'd0, board_hit}, 12'd0);
    chk("out400_rgb", {red, green, blue}, 12'h000);

    // Right-edge darken with saturation at 0
    mem[0] = 4'd2;
    repeat (3) pix(255, 90, 1, 1, 1);
    chk("dark_addr", {4'd0, cell_addr}, 12'd0);
    chk("dark_rgb", {red, green, blue}, 12'h0C0);

    // Corner (0,15): lighten wins, G saturates at F
    repeat (3) pix(240, 95, 1, 1, 1);
    chk("corner_rgb", {red, green, blue}, 12'h3F4);

    // Last cell
    mem[199] = 4'd3;
    pix(399, 399, 1, 1, 1);
    chk("last_addr", {4'd0, cell_addr}, 12'd199);
    repeat (2) pix(399, 399, 1, 1, 1);
    chk("last_hit", {11'd0, board_hit}, 12'd1);
    chk("last_rgb", {red, green, blue}, 12'h444);

    // Boundaries just outside
    repeat (3) pix(400, 399, 1, 1, 1);
    chk("x160_hit", {11'd0, board_hit}, 12'd0);
    chk("hold_addr", {4'd0, cell_addr}, 12'd199);
    repeat (3) pix(399, 400, 1, 1, 1);
    chk("y320_hit", {11'd0, board_hit}, 12'd0);
    repeat (3) pix(239, 80, 1, 1, 1);
    chk("xneg_hit", {11'd0, board_hit}, 12'd0);
    chk("xneg_rgb", {red, green, blue}, 12'h000);
    repeat (3) pix(300, 200, 0, 1, 1);
    chk("blank_hit", {11'd0, board_hit}, 12'd0);

    // hsync pulse of 96 strobes, delayed by 2 strobes
    for (int i = 0; i < 104; i++) begin
      pix(0, 0, 0, (i >= 4 && i < 100) ? 1'b0 : 1'b1, 1'b1);
      chk($sformatf("hs_s%0d", i), {11'd0, hs_out},
          ((i - 2) >= 4 && (i - 2) < 100) ? 12'd0 : 12'd1);
    end
    chk("hs_vs_idle", {11'd0, vs_out}, 12'd1);

    // Changing inputs with no strobe must leave everything unchanged
    hs_in = 1'b0; vs_in = 1'b0;
    repeat (6) @(negedge CLK);
    chk("hold_hs", {11'd0, hs_out}, 12'd1);
    chk("hold_vs", {11'd0, vs_out}, 12'd1);
    hs_in = 1'b1; vs_in = 1'b1;

    // Flashing cell code 9 -> palette[1]
    palette[1] = 12'h123;
    mem[0] = 4'd9;
    repeat (3) pix(245, 85, 1, 1, 1);
    chk("flash_f0", {red, green, blue}, 12'h123);
    for (int e = 0; e < 7; e++) begin
      pix(245, 85, 1, 1, 0);
      chk($sformatf("vs_e%0d", e), {11'd0, vs_out}, (e == 0) ? 12'd1 : 12'd0);
      pix(245, 85, 1, 1, 1);
    end
    repeat (3) pix(245, 85, 1, 1, 1);
    chk("flash_f7", {red, green, blue}, 12'h123);
    pix(245, 85, 1, 1, 0);
    pix(245, 85, 1, 1, 1);
    repeat (3) pix(245, 85, 1, 1, 1);
    chk("flash_f8", {red, green, blue}, 12'hFFF);
    for (int e = 0; e < 8; e++) begin
      pix(245, 85, 1, 1, 0);
      pix(245, 85, 1, 1, 1);
    end
    repeat (3) pix(245, 85, 1, 1, 1);
    chk("flash_f16", {red, green, blue}, 12'h123);

    // Reset in the middle of active board pixels
    mem[73] = 4'd4;
    repeat (3) pix(300, 200, 1, 0, 1);
    chk("pre_rst_addr", {4'd0, cell_addr}, 12'd73);
    chk("pre_rst_rgb", {red, green, blue}, 12'h5A3);
    chk("pre_rst_hs", {11'd0, hs_out}, 12'd0);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK);
    chk("rst_rgb",  {red, green, blue}, 12'h000);
    chk("rst_hit",  {11'd0, board_hit}, 12'd0);
    chk("rst_hs",   {11'd0, hs_out}, 12'd1);
    chk("rst_vs",   {11'd0, vs_out}, 12'd1);
    chk("rst_addr", {4'd0, cell_addr}, 12'd0);
    RESET = 1'b0;
    pix(300, 200, 1, 1, 1);
    chk("post_rst_s0", {11'd0, board_hit}, 12'd0);
    pix(300, 200, 1, 1, 1);
    chk("post_rst_s1", {11'd0, board_hit}, 12'd0);
    pix(300, 200, 1, 1, 1);
    chk("post_rst_s2_hit", {11'd0, board_hit}, 12'd1);
    chk("post_rst_s2_rgb", {red, green, blue}, 12'h5A3);

    // Empty cell: grid edge and interior
    mem[0] = 4'd0;
    repeat (3) pix(240, 85, 1, 1, 1);
    chk("empty_edge", {red, green, blue}, GRID_EXP);
    chk("empty_hit", {11'd0, board_hit}, 12'd1);
    repeat (3) pix(245, 85, 1, 1, 1);
    chk("empty_int", {red, green, blue}, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
